// File: rtl/fp_pkg.sv
// ============================================================================
//  Module      : fp_pkg
//  Description : Shared widths, FSM encoding and saturation constant for the
//                sequential single-precision divider.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fp_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int BIAS  = 127;
    localparam int ITER  = MAN_W + 2;
    localparam int FP_W  = 1 + EXP_W + MAN_W;
    localparam int EXT_W = EXP_W + 2;
    localparam int CNT_W = 5;

    localparam logic [FP_W-2:0] FP_MAX_MAG = 31'h7F7FFFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/fp_div_seq_if.sv
// ============================================================================
//  Module      : fp_div_seq_if
//  Description : Operand/result handshake bundle for fp_div_seq.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fp_div_seq_if;
    import fp_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [FP_W-1:0] N;
    logic [FP_W-1:0] D;
    logic            out_valid;
    logic            out_ready;
    logic [FP_W-1:0] P;
    logic            Exception;

    modport slave (
        input  in_valid, N, D, out_ready,
        output in_ready, out_valid, P, Exception
    );

    modport master (
        output in_valid, N, D, out_ready,
        input  in_ready, out_valid, P, Exception
    );

endinterface

`default_nettype wire

// File: rtl/fp_div_core.sv
// ============================================================================
//  Module      : fp_div_core
//  Description : One restoring radix-2 division step: {rem,div} -> {rem',qbit}.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_div_core
    import fp_pkg::*;
(
    input  wire logic [ITER-1:0]  rem_i,
    input  wire logic [MAN_W:0]   div_i,
    output logic      [ITER-1:0]  rem_o,
    output logic                  qbit_o
);

    logic [ITER-1:0] w_div_ext;
    logic [ITER-1:0] w_sel;

    assign w_div_ext = {1'b0, div_i};
    assign qbit_o    = (rem_i >= w_div_ext);
    assign w_sel     = qbit_o ? (rem_i - w_div_ext) : rem_i;
    // Partial remainder is always below div, so the shifted MSB is never lost.
    assign rem_o     = w_sel << 1;

endmodule

`default_nettype wire

// File: rtl/fp_div_seq.sv
// ============================================================================
//  Module      : fp_div_seq
//  Description : Sequential IEEE-754 single-precision divider P = N / D,
//                one quotient bit per clock, truncating, saturate/flush rules.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_div_seq
    import fp_pkg::*;
(
    input  wire logic     clk,
    input  wire logic     rst_n,
    fp_div_seq_if.slave   bus
);

    state_t                   state_q, state_d;
    logic                     sign_q, sign_d;
    logic signed [EXT_W-1:0]  e_un_q, e_un_d;
    logic [ITER-1:0]          rem_q, rem_d;
    logic [MAN_W:0]           div_q, div_d;
    logic [ITER-1:0]          quo_q, quo_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [FP_W-1:0]          p_q, p_d;
    logic                     exc_q, exc_d;

    logic [EXP_W-1:0]         w_en, w_ed;
    logic [MAN_W-1:0]         w_mn, w_md;
    logic                     w_sign, w_exc, w_n_zero;
    logic signed [EXT_W-1:0]  w_e_un;
    logic [ITER-1:0]          w_rem_next;
    logic                     w_qbit;
    logic signed [EXT_W-1:0]  w_e_norm;
    logic [MAN_W-1:0]         w_man;
    logic [FP_W-1:0]          w_packed;

    assign w_sign   = bus.N[FP_W-1] ^ bus.D[FP_W-1];
    assign w_en     = bus.N[FP_W-2:MAN_W];
    assign w_ed     = bus.D[FP_W-2:MAN_W];
    assign w_mn     = bus.N[MAN_W-1:0];
    assign w_md     = bus.D[MAN_W-1:0];
    assign w_exc    = (&w_en) | (&w_ed) | (w_ed == '0);
    assign w_n_zero = (w_en == '0);
    assign w_e_un   = $signed({2'b00, w_en}) - $signed({2'b00, w_ed})
                    + $signed(EXT_W'(BIAS));

    fp_div_core u_core (
        .rem_i  (rem_q),
        .div_i  (div_q),
        .rem_o  (w_rem_next),
        .qbit_o (w_qbit)
    );

    // Quotient lies in (0.5, 2): a clear top bit means one extra normalising shift.
    assign w_e_norm = quo_q[ITER-1] ? e_un_q : (e_un_q - EXT_W'(1));
    assign w_man    = quo_q[ITER-1] ? quo_q[ITER-2:1] : quo_q[ITER-3:0];
    assign w_packed = (w_e_norm >= $signed(EXT_W'(255))) ? {sign_q, FP_MAX_MAG} :
                      (w_e_norm <= $signed(EXT_W'(0)))   ? {sign_q, {(FP_W-1){1'b0}}} :
                                                           {sign_q, w_e_norm[EXP_W-1:0], w_man};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sign_q  <= 1'b0;
            e_un_q  <= '0;
            rem_q   <= '0;
            div_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            p_q     <= '0;
            exc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            e_un_q  <= e_un_d;
            rem_q   <= rem_d;
            div_q   <= div_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            exc_q   <= exc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        e_un_d  = e_un_q;
        rem_d   = rem_q;
        div_d   = div_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        exc_d   = exc_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    sign_d = w_sign;
                    exc_d  = w_exc;
                    // Invalid operands and a zero dividend resolve without iterating.
                    if (w_exc || w_n_zero) begin
                        state_d = DONE;
                        p_d     = w_exc ? {w_sign, FP_MAX_MAG} : {w_sign, {(FP_W-1){1'b0}}};
                    end else begin
                        state_d = CALC;
                        rem_d   = {1'b0, 1'b1, w_mn};
                        div_d   = {1'b1, w_md};
                        quo_d   = '0;
                        cnt_d   = CNT_W'(ITER - 1);
                        e_un_d  = w_e_un;
                    end
                end
            end
            CALC: begin
                rem_d        = w_rem_next;
                quo_d[cnt_q] = w_qbit;
                cnt_d        = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    state_d = NORM;
                end
            end
            NORM: begin
                p_d     = w_packed;
                exc_d   = 1'b0;
                state_d = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.P         = p_q;
    assign bus.Exception = exc_q;

endmodule

`default_nettype wire

// File: tb/tb_fp_div_seq.sv
// ============================================================================
//  Module      : tb_fp_div_seq
//  Description : Scoreboard bench for fp_div_seq against an integer-division
//                reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fp_div_seq;
    import fp_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   hold = 1'b0;

    typedef struct {
        logic [31:0] p;
        logic        exc;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];

    fp_div_seq_if bus();

    fp_div_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: exact integer quotient of the significands, then normalise.
    function automatic void model(input logic [31:0] n, input logic [31:0] d,
                                  output logic [31:0] p, output logic exc, output int lat);
        logic        s;
        int          en, ed, e;
        longint      a, b, q;
        logic [22:0] man;
        s   = n[31] ^ d[31];
        en  = int'(n[30:23]);
        ed  = int'(d[30:23]);
        exc = (en == 255) || (ed == 255) || (ed == 0);
        lat = 1;
        if (exc) begin
            p = {s, 31'h7F7FFFFF};
        end else if (en == 0) begin
            p = {s, 31'h0};
        end else begin
            lat = 27;
            a   = longint'(n[22:0]) + (longint'(1) << 23);
            b   = longint'(d[22:0]) + (longint'(1) << 23);
            q   = (a << 24) / b;
            e   = en - ed + 127;
            if (q >= (longint'(1) << 24)) begin
                man = 23'((q >> 1) & 64'h7FFFFF);
            end else begin
                man = 23'(q & 64'h7FFFFF);
                e   = e - 1;
            end
            if (e >= 255)     p = {s, 31'h7F7FFFFF};
            else if (e <= 0)  p = {s, 31'h0};
            else              p = {s, 8'(e), man};
        end
    endfunction

    task automatic issue(input logic [31:0] n, input logic [31:0] d, input bit expect_out);
        int   w;
        exp_t e;
        w = 0;
        while (!bus.in_ready && w < 300) begin
            @(posedge clk); #1;
            w++;
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: in_ready stuck low, required 1");
            return;
        end
        bus.in_valid = 1'b1;
        bus.N = n;
        bus.D = d;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.N = $urandom;
        bus.D = $urandom;
        if (expect_out) begin
            model(n, d, e.p, e.exc, e.lat);
            e.acc = cyc;
            sb.push_back(e);
        end
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 3000) begin
            @(posedge clk); #1;
            w++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            bus.out_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        bit          seen;
        logic [31:0] p0;
        logic        e0;
        exp_t        ex;
        seen = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && bus.out_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got P=%h with no request pending, required none", bus.P);
                end else begin
                    if (!seen) begin
                        seen = 1'b1;
                        p0   = bus.P;
                        e0   = bus.Exception;
                        check("latency", 32'(cyc - sb[0].acc + 1), 32'(sb[0].lat));
                    end else begin
                        check("stall_P_stable", bus.P, p0);
                        check("stall_exc_stable", {31'b0, bus.Exception}, {31'b0, e0});
                        check("stall_in_ready", {31'b0, bus.in_ready}, 32'd0);
                    end
                    if (bus.out_ready) begin
                        ex = sb.pop_front();
                        check("P", bus.P, ex.p);
                        check("Exception", {31'b0, bus.Exception}, {31'b0, ex.exc});
                        seen = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] dn [10];
        logic [31:0] dd [10];
        int          w;
        logic        s1, s2;
        logic [7:0]  en, ed;
        int          r;

        dn = '{32'h40C00000, 32'h3F800000, 32'hBF800000, 32'h3F800000, 32'h3F800000,
               32'h7F000000, 32'h00800000, 32'h00000000, 32'h7F800000, 32'hC1200000};
        dd = '{32'h40000000, 32'h40400000, 32'h40000000, 32'h00000000, 32'h7FC00000,
               32'h00800000, 32'h7F000000, 32'h40000000, 32'h3F800000, 32'h3FC00000};

        bus.in_valid = 1'b0;
        bus.N = '0;
        bus.D = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", {31'b0, bus.in_ready}, 32'd1);
        check("reset_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("reset_P", bus.P, 32'h0);
        check("reset_Exception", {31'b0, bus.Exception}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) issue(dn[i], dd[i], 1'b1);
        drain();

        for (int i = 0; i < 40; i++) begin
            r  = $urandom_range(0, 9);
            s1 = 1'($urandom);
            s2 = 1'($urandom);
            en = 8'($urandom_range(100, 154));
            ed = 8'($urandom_range(100, 154));
            case (r)
                0: ed = 8'h00;
                1: if ($urandom_range(0, 1) == 0) en = 8'hFF; else ed = 8'hFF;
                2: en = 8'h00;
                3: begin
                    en = 8'($urandom_range(1, 254));
                    ed = 8'($urandom_range(1, 254));
                end
                default: ;
            endcase
            issue({s1, en, 23'($urandom)}, {s2, ed, 23'($urandom)}, 1'b1);
        end
        drain();

        // Stalled result: new operands offered during DONE must not be taken.
        hold = 1'b1;
        @(posedge clk); #1;
        issue(32'h40C00000, 32'h40000000, 1'b1);
        w = 0;
        while (!bus.out_valid && w < 100) begin
            @(posedge clk); #1;
            w++;
        end
        check("bp_out_valid", {31'b0, bus.out_valid}, 32'd1);
        bus.in_valid = 1'b1;
        bus.N = 32'h3F800000;
        bus.D = 32'h40400000;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_in_ready", {31'b0, bus.in_ready}, 32'd0);
        end
        bus.in_valid = 1'b0;
        hold = 1'b0;
        drain();
        repeat (5) @(posedge clk);
        #1;

        // Asynchronous reset in the middle of an iteration.
        issue(32'h40C00000, 32'h40000000, 1'b0);
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("midreset_P", bus.P, 32'h0);
        check("midreset_in_ready", {31'b0, bus.in_ready}, 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("postreset_in_ready", {31'b0, bus.in_ready}, 32'd1);
        issue(32'h40C00000, 32'h40000000, 1'b1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
